// File: rtl/exe_alu_pkg.sv
// Shared types for the registered EXE-stage ALU: opcode set, NZCV bit
// positions, FSM states and a helper that assembles a flag nibble.
package exe_alu_pkg;

   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001,
      CMD_MUL = 4'b1010
   } exe_cmd_e;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } alu_state_e;

   function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/exe_alu_comb.sv
// Combinational single-cycle ALU datapath: result and NZCV for every opcode
// except the iterative multiply. Arithmetic is done at DATA_W+1 bits so the
// top bit is the carry-out (add) or borrow (subtract).
module exe_alu_comb
   import exe_alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
)(
   input  logic [3:0]        cmd_i,
   input  logic [DATA_W-1:0] val1_i,
   input  logic [DATA_W-1:0] val2_i,
   input  logic              c_i,
   input  logic              v_i,
   output logic [DATA_W-1:0] result_o,
   output logic [3:0]        flags_o
);

   localparam int unsigned MSB = DATA_W - 1;

   logic [DATA_W:0]   wide;
   logic [DATA_W-1:0] res;
   logic              c;
   logic              v;

   // Opcode decode; C and V default to the committed status (logical ops)
   always_comb begin
      wide = '0;
      res  = '0;
      c    = c_i;
      v    = v_i;
      case (cmd_i)
         CMD_MOV: res = val2_i;
         CMD_MVN: res = ~val2_i;
         CMD_AND: res = val1_i & val2_i;
         CMD_ORR: res = val1_i | val2_i;
         CMD_EOR: res = val1_i ^ val2_i;
         CMD_ADD, CMD_ADC: begin
            wide = {1'b0, val1_i} + {1'b0, val2_i}
                 + {{DATA_W{1'b0}}, (cmd_i == CMD_ADC) & c_i};
            res  = wide[MSB:0];
            c    = wide[DATA_W];
            v    = (val1_i[MSB] == val2_i[MSB]) && (res[MSB] != val1_i[MSB]);
         end
         CMD_SUB, CMD_SBC: begin
            wide = {1'b0, val1_i} - {1'b0, val2_i}
                 - {{DATA_W{1'b0}}, (cmd_i == CMD_SBC) & ~c_i};
            res  = wide[MSB:0];
            c    = ~wide[DATA_W];
            v    = (val1_i[MSB] != val2_i[MSB]) && (res[MSB] != val1_i[MSB]);
         end
         default: res = '0;
      endcase
   end

   // Result and N/Z derived from it
   always_comb begin
      result_o = res;
      flags_o  = pack_flags(res[MSB], res == '0, c, v);
   end

endmodule

// File: rtl/exe_alu_seq.sv
// Registered EXE-stage ALU with valid/ready handshake on both sides, owner of
// the architectural NZCV status register.
// Build option: define ALU_MUL_EN for the iterative shift-add multiply
// (opcode 1010, BUSY for DATA_W cycles); otherwise 1010 is an undefined op.
module exe_alu_seq
   import exe_alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CMD_W  = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CMD_W-1:0]  exe_cmd,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val2,
   input  logic              s_bit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags,
   output logic [3:0]        status
);

   alu_state_e        state_q, state_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [3:0]        flags_q, flags_d;
   logic [3:0]        status_q, status_d;

   logic [3:0]        cmd4;
   logic              accept;
   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_flags;

`ifdef ALU_MUL_EN
   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sbit_q, sbit_d;
   logic [DATA_W-1:0] mul_sum;
   logic [3:0]        mul_flags;
`endif

   assign cmd4      = 4'(exe_cmd);
   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign flags     = flags_q;
   assign status    = status_q;

   // Operands feed the datapath directly; C/V come from the committed status,
   // which already holds the DONE op's commit when accepting back-to-back.
   exe_alu_comb #(
      .DATA_W (DATA_W)
   ) u_comb (
      .cmd_i    (cmd4),
      .val1_i   (val1),
      .val2_i   (val2),
      .c_i      (status_q[FLAG_C]),
      .v_i      (status_q[FLAG_V]),
      .result_o (alu_res),
      .flags_o  (alu_flags)
   );

`ifdef ALU_MUL_EN
   // One partial product per BUSY cycle: multiplicand shifts left, multiplier right
   always_comb begin
      mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
      mul_flags = pack_flags(mul_sum[DATA_W-1], mul_sum == '0,
                             status_q[FLAG_C], status_q[FLAG_V]);
   end
`endif

   // Next-state, result capture and status commit
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      status_d = status_q;
`ifdef ALU_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sbit_d   = sbit_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if ((state_q == DONE) && out_ready) begin
               state_d = IDLE;
            end
            if (accept) begin
`ifdef ALU_MUL_EN
               if (cmd4 == CMD_MUL) begin
                  state_d  = BUSY;
                  mcand_d  = val1;
                  mplier_d = val2;
                  acc_d    = '0;
                  cnt_d    = '0;
                  sbit_d   = s_bit;
               end else
`endif
               begin
                  state_d  = DONE;
                  result_d = alu_res;
                  flags_d  = alu_flags;
                  if (s_bit) begin
                     status_d = alu_flags;
                  end
               end
            end
         end
`ifdef ALU_MUL_EN
         BUSY: begin
            acc_d    = mul_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d  = DONE;
               result_d = mul_sum;
               flags_d  = mul_flags;
               if (sbit_q) begin
                  status_d = mul_flags;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State and architectural registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         flags_q  <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         status_q <= status_d;
      end
   end

`ifdef ALU_MUL_EN
   // Multiplier working registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sbit_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sbit_q   <= sbit_d;
      end
   end
`endif

endmodule

// File: tb/tb_exe_alu_seq.sv
// Self-checking bench for exe_alu_seq (DATA_W=32). Expected values come from
// an arithmetic reference model using 64-bit integer ranges for carry/overflow.
module tb_exe_alu_seq;

   localparam int unsigned DW = 32;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [3:0]    exe_cmd   = '0;
   logic [DW-1:0] val1      = '0;
   logic [DW-1:0] val2      = '0;
   logic          s_bit     = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] result;
   logic [3:0]    flags;
   logic [3:0]    status;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [3:0]  m_st     = '0;

   always #5 clk = ~clk;

   exe_alu_seq #(
      .DATA_W (DW),
      .CMD_W  (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .exe_cmd   (exe_cmd),
      .val1      (val1),
      .val2      (val2),
      .s_bit     (s_bit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .status    (status)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference: flags {N,Z,C,V}; carry/borrow from unsigned ranges, V from signed range
   function automatic void model(input logic [3:0] cmd, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] st,
                                 output logic [31:0] r, output logic [3:0] f);
      longint unsigned ua, ub, uw, k;
      longint          sa, sb, sw;
      logic            c, v;
      ua = a; ub = b;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c  = st[1];
      v  = st[0];
      r  = '0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         4'd2, 4'd3: begin
            k  = (cmd == 4'd3 && st[1]) ? 1 : 0;
            uw = ua + ub + k;
            sw = sa + sb + longint'(k);
            r  = uw[31:0];
            c  = (uw > 64'hFFFF_FFFF);
            v  = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
         end
         4'd4, 4'd5: begin
            k  = (cmd == 4'd5 && !st[1]) ? 1 : 0;
            uw = ua - ub - k;
            sw = sa - sb - longint'(k);
            r  = uw[31:0];
            c  = (ua >= ub + k);
            v  = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
         end
`ifdef ALU_MUL_EN
         4'd10: begin
            uw = ua * ub;
            r  = uw[31:0];
         end
`endif
         default: r = '0;
      endcase
      f = {r[31], (r == 0), c, v};
   endfunction

   // Offer a single-cycle op with out_ready high; check it one cycle later
   task automatic op_single(input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic s);
      logic [31:0] er;
      logic [3:0]  ef;
      model(c, a, b, m_st, er, ef);
      exe_cmd = c; val1 = a; val2 = b; s_bit = s;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("in_ready", in_ready, 1);
      @(negedge clk);
      if (s) m_st = ef;
      chk("out_valid", out_valid, 1);
      chk("result", result, er);
      chk("flags", flags, ef);
      chk("status", status, m_st);
   endtask

`ifdef ALU_MUL_EN
   // Multiply: in_valid dropped after accept, completion waited with a bound
   task automatic op_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] er;
      logic [3:0]  ef;
      int          n;
      model(4'd10, a, b, m_st, er, ef);
      exe_cmd = 4'd10; val1 = a; val2 = b; s_bit = s;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("mul_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      chk("busy_in_ready", in_ready, 0);
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mul_latency", n, DW + 1);
      if (s) m_st = ef;
      chk("mul_result", result, er);
      chk("mul_flags", flags, ef);
      chk("mul_status", status, m_st);
   endtask
`endif

   task automatic run_op(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
`ifdef ALU_MUL_EN
      if (c == 4'd10) op_mul(a, b, s);
      else op_single(c, a, b, s);
`else
      op_single(c, a, b, s);
`endif
   endtask

   task automatic go_idle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("idle_out_valid", out_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bp_res, er, a, b;
      logic [3:0]  ef, c;

      // Reset values
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_status", status, 0);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Unsigned wrap: carry out, zero result
      op_single(4'd2, 32'hFFFF_FFFF, 32'h1, 1'b1);
      chk("add_wrap_result", result, 0);
      chk("add_wrap_flags", flags, 4'b0110);
      chk("add_wrap_status", status, 4'b0110);

      // SUB borrows (C=0), SBC back-to-back consumes that borrow
      op_single(4'd4, 32'd5, 32'd7, 1'b1);
      chk("sub_result", result, 32'hFFFF_FFFE);
      chk("sub_n", flags[3], 1);
      chk("sub_c", flags[1], 0);
      op_single(4'd5, 32'd10, 32'd3, 1'b1);
      chk("sbc_result", result, 6);
      go_idle();

      // Signed overflow
      op_single(4'd2, 32'h7FFF_FFFF, 32'h1, 1'b1);
      chk("ovf_result", result, 32'h8000_0000);
      chk("ovf_flags", flags, 4'b1001);

      // Backpressure after an AND result
      op_single(4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
      bp_res = result;
      model(4'd7, 32'h1111_0000, 32'h0000_2222, m_st, er, ef);
      exe_cmd = 4'd7; val1 = 32'h1111_0000; val2 = 32'h0000_2222; s_bit = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_result", result, bp_res);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_in_ready", in_ready, 1);
      @(negedge clk);
      chk("bp_next_result", result, er);
      chk("bp_next_flags", flags, ef);
      go_idle();

      // Multiply (or undefined opcode without the multiplier)
      run_op(4'd10, 32'h1234, 32'h10, 1'b0);
`ifdef ALU_MUL_EN
      chk("mul_const", result, 32'h12340);
`else
      chk("mul_const", result, 0);
`endif
      go_idle();

      // Randomised ops against the model
      for (int i = 0; i < 40; i++) begin
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) b = a;
         run_op(c, a, b, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 4) == 0) go_idle();
      end
      go_idle();

      // Asynchronous reset mid-operation clears outputs and status at once
      op_single(4'd2, 32'h7FFF_FFFF, 32'h1, 1'b1);
      exe_cmd = 4'd10; val1 = 32'hFFFF; val2 = 32'hFF; s_bit = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_status", status, 0);
      chk("arst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_st  = '0;
      #1 chk("arst_in_ready", in_ready, 1);
      @(negedge clk);
      chk("arst_no_done", out_valid, 0);
      op_single(4'd3, 32'd1, 32'd1, 1'b1);
      chk("adc_after_rst", result, 2);
      go_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/exe_alu_seq.md
Name: exe_alu_seq

Overview:
- Parametrised, registered successor of the single-cycle EXE-stage ALU.
- Executes the EXE_CMD opcode set at DATA_W bits with a valid/ready handshake on both sides.
- Owns the architectural NZCV status register and applies ARM carry/borrow semantics.
- Adds an iterative multi-cycle multiply. Sits between ID/EXE pipeline registers and the EXE/MEM register.

Parameters:
- DATA_W, 32, operand/result width (>=8).
- CMD_W, 4, EXE_CMD width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts operation this cycle
- exe_cmd  in  CMD_W  opcode
- val1  in  DATA_W  operand 1 (Rn)
- val2  in  DATA_W  operand 2 (shifter output)
- s_bit  in  1  update status register with this op's flags
- out_valid  out  1  result held
- out_ready  in  1  downstream takes result
- result  out  DATA_W  registered result
- flags  out  4  flags of this result {N,Z,C,V}
- status  out  4  committed status register {N,Z,C,V}; C is bit 1

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1 after deassert, out_valid=0, result=0, flags=0, status=0. Reset mid-multiply aborts the op; no flag commit.
- Accept when in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM: IDLE -accept single-cycle op-> DONE; IDLE -accept MUL-> BUSY; BUSY -counter==DATA_W-1-> DONE; DONE -out_ready && !accept-> IDLE; DONE -out_ready && accept-> DONE or BUSY, per new op.
- Latency: single-cycle ops out_valid the cycle after accept; MUL out_valid DATA_W+1 cycles after accept. Back-to-back single-cycle throughput is 1/cycle with out_ready held high.
- Opcodes: 0001 MOV=val2; 1001 MVN=~val2; 0010 ADD; 0011 ADC=val1+val2+C; 0100 SUB; 0101 SBC=val1-val2-!C; 0110 AND; 0111 ORR; 1000 EOR; 1010 MUL (low DATA_W bits of product); all others result=0, flags computed as for logical ops.
- Arithmetic on DATA_W+1 bits. ADD/ADC: C=carry-out. SUB/SBC: C=NOT borrow, i.e. val1 >= val2 (+borrow-in), so C=1 when no borrow. V: add = sign(a)==sign(b) && sign(r)!=sign(a); sub = sign(a)!=sign(b) && sign(r)!=sign(a).
- N=result[DATA_W-1]; Z=(result==0). Logical ops, MOV, MVN and MUL keep C and V from status.
- C used by ADC/SBC is the status value at accept time, which already includes any commit from the op in DONE.
- Status commit: status <= flags on entry to DONE when the accepted op had s_bit=1; otherwise status holds.
- result and flags are stable while out_valid && !out_ready.
- in_valid deasserted while BUSY is ignored; operands are latched at accept.

Optional Feature:
- ALU_MUL_EN defined: MUL is a shift-add iterative multiply, one partial product per cycle, BUSY for DATA_W cycles.
- ALU_MUL_EN undefined: no BUSY state or counter logic; 1010 is treated as an undefined opcode (result 0, single-cycle).

Decomposition:
- Package exe_alu_pkg: exe_cmd_e enum (CMD_MOV..CMD_MUL), flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, alu_state_e {IDLE,BUSY,DONE}.
- One sub-module, exe_alu_comb: the combinational single-cycle datapath (result plus NZCV for non-MUL ops), parametrised by DATA_W.
- The FSM, multiplier and status register stay in the top module.

Test Plan:
- Reset: rst_n=0 asynchronously mid-MUL (BUSY) -> out_valid=0, status=0000 immediately; after release in_ready=1.
- ADD with s_bit=1, val1=0xFFFFFFFF, val2=1 -> result=0, flags=0110 (Z,C), status=0110 one cycle after accept.
- SUB then SBC chain: SUB 5-7 with s_bit=1 -> result=0xFFFFFFFE, flags N=1, C=0; back-to-back SBC 10-3 -> result=6 (borrow applied from committed C=0).
- Signed overflow: ADD 0x7FFFFFFF+1 with s_bit=1 -> result=0x80000000, flags=1001.
- Backpressure: out_ready=0 for 5 cycles after an AND result -> result/out_valid stable, in_ready=0; new op accepted on the out_ready=1 cycle.
- With ALU_MUL_EN: MUL 0x1234*0x10 -> result=0x12340 after 33 cycles (DATA_W=32); C and V unchanged. Without ALU_MUL_EN: the same op gives result 0 after 1 cycle.
